// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD core driver and its controller bench:
// driver state encoding and default sizing.
package gcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_A = 3'd1,
    ST_LOAD_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CLEAR  = 3'd4,
    ST_RESP   = 3'd5
  } gcd_state_t;

  localparam int GCD_W          = 16;
  localparam int GCD_TIMEOUT    = 1024;
  localparam int GCD_CLR_CYCLES = 2;

endpackage

// File: rtl/gcd_watchdog.sv
// Saturating cycle counter that bounds how long the driver waits for the core.
module gcd_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] MAX  = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable && (cnt != MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Flags the TIMEOUT-th enabled cycle, so WAIT lasts at most TIMEOUT cycles.
  assign expired = enable && (cnt >= LAST);

endmodule

// File: rtl/gcd_job_driver.sv
// Initiator for the GCD core start/ldA/ldB/done handshake: takes operand pairs,
// loads A then B on the shared bus, waits for done, clears the core, returns the result.
module gcd_job_driver
  import gcd_pkg::*;
#(
  parameter int W          = GCD_W,
  parameter int TIMEOUT    = GCD_TIMEOUT,
  parameter int CLR_CYCLES = GCD_CLR_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         gcd_start,
  output logic [W-1:0] gcd_data_in,
  output logic         gcd_clr,
  input  logic         gcd_done,
  input  logic [W-1:0] gcd_result,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_err,
  output logic [2:0]   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
  // valid, once raised, holds its payload stable until that edge.

  localparam int CCW = $clog2(CLR_CYCLES + 1);

  gcd_state_t     state, state_n;
  logic [W-1:0]   b_q;
  logic [CCW-1:0] clr_cnt, flush_cnt;
  logic           accept, zero_op, expired;
  logic           op_ready_d, start_d, clr_d, res_valid_d;
  logic [W-1:0]   data_in_d;

  assign accept    = (state == ST_IDLE) && op_ready && op_valid;
  assign zero_op   = (op_a == '0) || (op_b == '0);
  assign dbg_state = state;

  gcd_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == ST_LOAD_B),
    .enable  (state == ST_WAIT),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = zero_op ? ST_RESP : ST_LOAD_A;
      ST_LOAD_A: state_n = ST_LOAD_B;
      ST_LOAD_B: state_n = ST_WAIT;
      ST_WAIT:   if (gcd_done || expired) state_n = ST_CLEAR;
      ST_CLEAR:  if (clr_cnt == '0) state_n = ST_RESP;
      ST_RESP:   if (res_ready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up with state.
  // The post-reset flush gives way if a job launches before it completes.
  always_comb begin
    op_ready_d  = (state_n == ST_IDLE);
    start_d     = (state_n == ST_LOAD_A);
    res_valid_d = (state_n == ST_RESP);
    clr_d       = (state_n == ST_CLEAR) || ((state_n == ST_IDLE) && (flush_cnt != '0));
    case (state_n)
      ST_LOAD_A:         data_in_d = op_a;
      ST_LOAD_B, ST_WAIT: data_in_d = b_q;
      default:           data_in_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_ready    <= 1'b0;
      gcd_start   <= 1'b0;
      gcd_data_in <= '0;
      gcd_clr     <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_err     <= 1'b0;
      b_q         <= '0;
      clr_cnt     <= '0;
      flush_cnt   <= CCW'(CLR_CYCLES);
    end else begin
      op_ready    <= op_ready_d;
      gcd_start   <= start_d;
      gcd_data_in <= data_in_d;
      gcd_clr     <= clr_d;
      res_valid   <= res_valid_d;
      if (flush_cnt != '0) flush_cnt <= flush_cnt - CCW'(1);
      if (accept) begin
        b_q      <= op_b;
        res_data <= zero_op ? (op_a | op_b) : '0;
        res_err  <= 1'b0;
      end
      // Done wins over a simultaneous timeout.
      if ((state == ST_WAIT) && (state_n == ST_CLEAR)) begin
        clr_cnt  <= CCW'(CLR_CYCLES - 1);
        res_data <= gcd_done ? gcd_result : '0;
        res_err  <= !gcd_done;
      end else if ((state == ST_CLEAR) && (clr_cnt != '0)) begin
        clr_cnt <= clr_cnt - CCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_gcd_job_driver.sv
// Bench for gcd_job_driver: behavioural GCD core with programmable latency,
// directed corner cases followed by randomized jobs against a reference model.
module tb_gcd_job_driver;
  import gcd_pkg::*;

  localparam int W   = 16;
  localparam int TO  = 16;
  localparam int CLR = 2;

  logic         clk, rst;
  logic         op_valid, op_ready;
  logic [W-1:0] op_a, op_b;
  logic         gcd_start, gcd_clr, gcd_done;
  logic [W-1:0] gcd_data_in, gcd_result;
  logic         res_valid, res_ready, res_err;
  logic [W-1:0] res_data;
  logic [2:0]   dbg_state;

  gcd_job_driver #(.W(W), .TIMEOUT(TO), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .gcd_start(gcd_start), .gcd_data_in(gcd_data_in), .gcd_clr(gcd_clr), .gcd_done(gcd_done),
    .gcd_result(gcd_result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return W'(x);
  endfunction

  // ---------------- behavioural GCD core ----------------
  int unsigned  m_lat = 1;
  bit           m_never = 1'b0;
  bit           spurious = 1'b0;
  int           m_phase = 0;
  int           m_wait = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic         m_done = 1'b0;

  assign gcd_done   = m_done | spurious;
  assign gcd_result = spurious ? W'(16'hBEEF) : m_res;

  // Samples the driver mid-cycle; done is raised in the m_lat-th cycle after B is loaded.
  always @(negedge clk) begin
    if (gcd_clr) begin
      m_phase = 0;
      m_done  = 1'b0;
    end else if (gcd_start) begin
      m_a     = gcd_data_in;
      m_phase = 1;
      m_done  = 1'b0;
    end else if (m_phase == 1) begin
      m_b     = gcd_data_in;
      m_phase = 2;
      m_wait  = 0;
    end else if (m_phase == 2 && !m_done) begin
      m_wait++;
      if (!m_never && m_wait >= int'(m_lat)) begin
        m_done = 1'b1;
        m_res  = ref_gcd(m_a, m_b);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_op_ready"}, op_ready, 1'b0);
    check_eq({tag, "_start"}, gcd_start, 1'b0);
    check_eq({tag, "_data_in"}, gcd_data_in, '0);
    check_eq({tag, "_clr"}, gcd_clr, 1'b1);
    check_eq({tag, "_res_valid"}, res_valid, 1'b0);
    check_eq({tag, "_res_data"}, res_data, '0);
    check_eq({tag, "_res_err"}, res_err, 1'b0);
    check_eq({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  task automatic check_flush(input string tag);
    int clrs;
    clrs = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      clrs += int'(gcd_clr);
      if (i == 0) check_eq({tag, "_op_ready"}, op_ready, 1'b1);
    end
    check_eq({tag, "_flush_cycles"}, clrs, CLR);
  endtask

  task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                         input bit never, input int hold);
    bit           nz;
    int           n, starts, clrs, stable;
    bit           rdy_seen;
    logic [W-1:0] e;
    logic         ee;
    nz = (a != 0) && (b != 0);
    if (!nz) begin
      exp_q.push_back(a | b);
      exp_err_q.push_back(1'b0);
    end else if (never || lat > TO) begin
      exp_q.push_back('0);
      exp_err_q.push_back(1'b1);
    end else begin
      exp_q.push_back(ref_gcd(a, b));
      exp_err_q.push_back(1'b0);
    end
    m_lat   = lat;
    m_never = never;

    n = 0;
    while (!op_ready && n < 50) begin step(); n++; end
    check_eq("op_ready_before_job", op_ready, 1'b1);
    op_valid = 1'b1; op_a = a; op_b = b;
    step();
    op_valid = 1'b0; op_a = W'($urandom); op_b = W'($urandom);
    if (nz) begin
      check_eq("load_a_start", gcd_start, 1'b1);
      check_eq("load_a_data", gcd_data_in, a);
      step();
      check_eq("load_b_start", gcd_start, 1'b0);
      check_eq("load_b_data", gcd_data_in, b);
    end else begin
      check_eq("zero_latency_valid", res_valid, 1'b1);
      check_eq("zero_no_start", gcd_start, 1'b0);
    end

    // Stray operand offers while busy must be ignored.
    op_valid = 1'b1;
    starts = 0; clrs = 0; rdy_seen = 1'b0; n = 0;
    while (!res_valid && n < 100) begin
      step();
      n++;
      starts += int'(gcd_start);
      clrs   += int'(gcd_clr);
      rdy_seen |= op_ready;
    end
    check_eq("res_valid_arrives", res_valid, 1'b1);
    check_eq("start_pulses_in_wait", starts, 0);
    check_eq("clr_cycles", clrs, nz ? CLR : 0);
    check_eq("op_ready_low_busy", rdy_seen, 1'b0);
    e  = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    check_eq("res_data", res_data, e);
    check_eq("res_err", res_err, ee);

    stable = 1;
    for (int i = 0; i < hold; i++) begin
      res_ready = 1'b0;
      step();
      if (!res_valid || res_data !== e || res_err !== ee || op_ready) stable = 0;
    end
    if (hold > 0) check_eq("res_stall_stable", stable, 1);
    op_valid = 1'b0;

    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check_eq("res_valid_drops", res_valid, 1'b0);
    check_eq("op_ready_after_resp", op_ready, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int           starts, valids;
    logic [W-1:0] ra, rb;
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    check_flush("post_reset");

    run_job(16'd48, 16'd18, 5, 1'b0, 0);
    run_job(16'd0, 16'd35, 1, 1'b0, 0);
    run_job(16'd0, 16'd0, 1, 1'b0, 0);
    run_job(16'd35, 16'd0, 1, 1'b0, 0);
    run_job(16'd40, 16'd24, 1, 1'b1, 0);
    run_job(16'd21, 16'd14, 4, 1'b0, 0);
    run_job(16'd25, 16'd15, 3, 1'b0, 10);

    // Reset in the middle of WAIT aborts the job without a result.
    m_never = 1'b1;
    while (!op_ready) step();
    op_valid = 1'b1; op_a = 16'd40; op_b = 16'd24;
    step();
    op_valid = 1'b0;
    repeat (5) step();
    check_eq("midjob_in_wait", dbg_state, ST_WAIT);
    rst = 1'b1;
    step();
    check_reset_outputs("midjob_reset");
    rst = 1'b0;
    check_flush("midjob_flush");
    spurious = 1'b1;
    starts = 0; valids = 0;
    repeat (4) begin
      step();
      starts += int'(gcd_start);
      valids += int'(res_valid);
    end
    spurious = 1'b0;
    check_eq("spurious_no_valid", valids, 0);
    check_eq("spurious_no_start", starts, 0);
    run_job(16'd9, 16'd6, 3, 1'b0, 0);

    // Done landing on the last watchdog cycle wins; one cycle later is a timeout.
    run_job(16'd28, 16'd12, TO, 1'b0, 0);
    run_job(16'd28, 16'd12, TO + 1, 1'b0, 0);

    for (int j = 0; j < 25; j++) begin
      ra = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 500));
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 500));
      run_job(ra, rb, $urandom_range(1, 20), 1'b0, $urandom_range(0, 3));
    end

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
